// File: rtl/axil_ctrl_initiator.sv
// axil_ctrl_initiator: AXI4-Lite master that turns a simple command stream into
// single-beat register writes/reads on a control slave, one transaction at a time.
// Ports:
//   aclk, areset            clock and synchronous active-high reset
//   cmd_*                   command stream in (valid/ready, write, addr, wdata, wstrb)
//   rsp_*                   response stream out (valid/ready, rdata, resp, timeout)
//   err_sticky              set on any non-OKAY response or timeout, cleared by reset
//   m_axil_*                AXI4-Lite master channels AW, W, B, AR, R
module axil_ctrl_initiator #(
    parameter int unsigned ADDR_BITS      = 64,
    parameter int unsigned DATA_BITS      = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDR_BITS-1:0]   cmd_addr,
    input  logic [DATA_BITS-1:0]   cmd_wdata,
    input  logic [DATA_BITS/8-1:0] cmd_wstrb,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_BITS-1:0]   rsp_rdata,
    output logic [1:0]             rsp_resp,
    output logic                   rsp_timeout,
    output logic                   err_sticky,
    output logic [ADDR_BITS-1:0]   m_axil_awaddr,
    output logic [2:0]             m_axil_awprot,
    output logic                   m_axil_awvalid,
    input  logic                   m_axil_awready,
    output logic [DATA_BITS-1:0]   m_axil_wdata,
    output logic [DATA_BITS/8-1:0] m_axil_wstrb,
    output logic                   m_axil_wvalid,
    input  logic                   m_axil_wready,
    input  logic [1:0]             m_axil_bresp,
    input  logic                   m_axil_bvalid,
    output logic                   m_axil_bready,
    output logic [ADDR_BITS-1:0]   m_axil_araddr,
    output logic [2:0]             m_axil_arprot,
    output logic                   m_axil_arvalid,
    input  logic                   m_axil_arready,
    input  logic [DATA_BITS-1:0]   m_axil_rdata,
    input  logic [1:0]             m_axil_rresp,
    input  logic                   m_axil_rvalid,
    output logic                   m_axil_rready
);

    localparam int unsigned STRB_BITS = DATA_BITS / 8;
    // +2 keeps the width at least one bit when the timeout is disabled.
    localparam int unsigned TMR_BITS  = $clog2(TIMEOUT_CYCLES + 2);

    typedef enum logic [2:0] {StIdle, StWrReq, StWrResp, StRdReq, StRdResp, StRsp} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [DATA_BITS-1:0]   wdata_q;
    logic [STRB_BITS-1:0]   wstrb_q;
    logic                   aw_done_q, w_done_q;
    logic [TMR_BITS-1:0]    timer_q, timer_d;
    logic                   tmo_q, tmo_d;
    logic [DATA_BITS-1:0]   rdata_q;
    logic [1:0]             resp_q, resp_d;
    logic                   err_q;

    logic accept, busy, aw_ok, w_ok, cap_b, cap_r;

    // Datapath next-state helpers
    always_comb begin
        accept  = (state_q == StIdle) && cmd_valid;
        busy    = (state_q == StWrReq) || (state_q == StWrResp) ||
                  (state_q == StRdReq) || (state_q == StRdResp);
        // A channel counts as done once its handshake has happened, now or earlier.
        aw_ok   = aw_done_q || m_axil_awready;
        w_ok    = w_done_q  || m_axil_wready;
        cap_b   = (state_q == StWrResp) && m_axil_bvalid;
        cap_r   = (state_q == StRdResp) && m_axil_rvalid;
        resp_d  = cap_b ? m_axil_bresp : m_axil_rresp;
        // Saturating timer; tmo latches once the budget is reached and never aborts the FSM.
        timer_d = (timer_q == TMR_BITS'(TIMEOUT_CYCLES)) ? timer_q : timer_q + 1'b1;
        tmo_d   = tmo_q | ((TIMEOUT_CYCLES != 0) && (timer_d == TMR_BITS'(TIMEOUT_CYCLES)));
    end

    // FSM state register
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (cmd_valid) state_d = cmd_write ? StWrReq : StRdReq;
            StWrReq:  if (aw_ok && w_ok) state_d = StWrResp;
            StWrResp: if (m_axil_bvalid) state_d = StRsp;
            StRdReq:  if (m_axil_arready) state_d = StRdResp;
            StRdResp: if (m_axil_rvalid) state_d = StRsp;
            StRsp:    if (rsp_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Datapath registers
    always_ff @(posedge aclk) begin
        if (areset) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            timer_q   <= '0;
            tmo_q     <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                addr_q    <= cmd_addr;
                wdata_q   <= cmd_wdata;
                wstrb_q   <= cmd_wstrb;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
                timer_q   <= '0;
                tmo_q     <= 1'b0;
            end
            if (busy) begin
                timer_q <= timer_d;
                tmo_q   <= tmo_d;
            end
            if (state_q == StWrReq) begin
                aw_done_q <= aw_ok;
                w_done_q  <= w_ok;
            end
            if (cap_b || cap_r) begin
                rdata_q <= cap_r ? m_axil_rdata : '0;
                resp_q  <= resp_d;
                // Evaluated with the values rsp_* will show when rsp_valid rises.
                if ((resp_d != 2'b00) || tmo_d) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    // FSM / interface outputs
    always_comb begin
        cmd_ready      = (state_q == StIdle) && !areset;
        m_axil_awaddr  = addr_q;
        m_axil_awprot  = 3'b000;
        m_axil_awvalid = (state_q == StWrReq) && !aw_done_q;
        m_axil_wdata   = wdata_q;
        m_axil_wstrb   = wstrb_q;
        m_axil_wvalid  = (state_q == StWrReq) && !w_done_q;
        m_axil_bready  = (state_q == StWrResp);
        m_axil_araddr  = addr_q;
        m_axil_arprot  = 3'b000;
        m_axil_arvalid = (state_q == StRdReq);
        m_axil_rready  = (state_q == StRdResp);
        rsp_valid      = (state_q == StRsp);
        rsp_rdata      = rdata_q;
        rsp_resp       = resp_q;
        rsp_timeout    = tmo_q;
        err_sticky     = err_q;
    end

endmodule
